// File: rtl/glitch_sweep_pkg.sv
// Shared glitch defines: register map, sweep FSM encoding and the bus request payload.
package glitch_sweep_pkg;

    localparam int unsigned ADR_W = 4;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned DLY_W = 16;
    localparam int unsigned WID_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [ADR_W-1:0] GLITCH_MODE    = 4'h0;
    localparam logic [ADR_W-1:0] GLITCH_WIDTH   = 4'h1;
    localparam logic [ADR_W-1:0] GLITCH_DELAY_0 = 4'h2;
    localparam logic [ADR_W-1:0] GLITCH_DELAY_1 = 4'h3;
    localparam logic [ADR_W-1:0] GLITCH_STATUS  = 4'h4;

    localparam logic [DAT_W-1:0] STATUS_FIRE  = 8'h01;
    localparam logic [DAT_W-1:0] STATUS_READY = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_WID,
        ST_WR_DLY0,
        ST_WR_DLY1,
        ST_FIRE,
        ST_SETTLE,
        ST_POLL,
        ST_HOLDOFF,
        ST_NEXT,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/glitch_sweep_wb_master_xfer.sv
// Single Wishbone transfer: launches on req_i, holds the cycle until ack_i, then
// pulses done_o with stb/cyc already low so back-to-back requests leave a gap.
module wb_master_xfer
    import glitch_sweep_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  wb_req_t          req_pld_i,
    output logic             done_o,
    output logic [DAT_W-1:0] rdat_o,
    output logic             busy_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    output logic             we_o,
    output logic             stb_o,
    output logic             cyc_o,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             ack_i
);

    typedef enum logic [1:0] {X_IDLE, X_ACTIVE, X_DONE} xstate_e;

    xstate_e          xstate_q, xstate_d;
    wb_req_t          pld_q, pld_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;
    logic [DAT_W-1:0] rdat_q, rdat_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            xstate_q <= X_IDLE;
            pld_q    <= '0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
            rdat_q   <= '0;
        end else begin
            xstate_q <= xstate_d;
            pld_q    <= pld_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
            rdat_q   <= rdat_d;
        end
    end

    // X_DONE refuses a new request, guaranteeing a stb-low cycle between transfers.
    always_comb begin
        xstate_d = xstate_q;
        pld_d    = pld_q;
        stb_d    = stb_q;
        done_d   = 1'b0;
        rdat_d   = rdat_q;
        case (xstate_q)
            X_IDLE: begin
                if (req_i) begin
                    xstate_d = X_ACTIVE;
                    pld_d    = req_pld_i;
                    stb_d    = 1'b1;
                end
            end
            X_ACTIVE: begin
                if (ack_i) begin
                    xstate_d = X_DONE;
                    stb_d    = 1'b0;
                    done_d   = 1'b1;
                    rdat_d   = dat_i;
                end
            end
            X_DONE: xstate_d = X_IDLE;
            default: begin
                xstate_d = X_IDLE;
                stb_d    = 1'b0;
            end
        endcase
    end

    assign done_o = done_q;
    assign rdat_o = rdat_q;
    assign busy_o = stb_q;
    assign adr_o  = pld_q.adr;
    assign dat_o  = pld_q.dat;
    assign we_o   = pld_q.we;
    assign stb_o  = stb_q;
    assign cyc_o  = stb_q;

endmodule

// File: rtl/glitch_sweep.sv
// Glitch parameter sweep: width outer loop, delay inner loop; each attempt programs the
// glitch slave over Wishbone, fires it and polls status until the glitch has completed.
module glitch_sweep
    import glitch_sweep_pkg::*;
#(
    parameter int unsigned SETTLE       = 4,
    parameter int unsigned POLL_TIMEOUT = 65535,
    parameter int unsigned HOLDOFF      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DAT_W-1:0] mode_i,
    input  logic [DLY_W-1:0] dly_start_i,
    input  logic [DLY_W-1:0] dly_stop_i,
    input  logic [DLY_W-1:0] dly_step_i,
    input  logic [WID_W-1:0] wid_start_i,
    input  logic [WID_W-1:0] wid_stop_i,
    input  logic [WID_W-1:0] wid_step_i,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    output logic             we_o,
    output logic             stb_o,
    output logic             cyc_o,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             timeout_o,
    output logic [DLY_W-1:0] cur_delay_o,
    output logic [WID_W-1:0] cur_width_o,
    output logic [CNT_W-1:0] attempt_cnt_o
);

    state_e           state_q, state_d;
    logic [DAT_W-1:0] mode_q, mode_d;
    logic [DLY_W-1:0] dly_start_q, dly_start_d, dly_stop_q, dly_stop_d, dly_step_q, dly_step_d;
    logic [WID_W-1:0] wid_start_q, wid_start_d, wid_stop_q, wid_stop_d, wid_step_q, wid_step_d;
    logic [DLY_W-1:0] cur_dly_q, cur_dly_d;
    logic [WID_W-1:0] cur_wid_q, cur_wid_d;
    logic [CNT_W-1:0] attempt_q, attempt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] poll_q, poll_d;
    logic             abort_pend_q, abort_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             timeout_q, timeout_d;

    logic             xfer_req_c;
    wb_req_t          xfer_pld_c;
    logic             xfer_done;
    logic             xfer_busy;
    logic [DAT_W-1:0] xfer_rdat;

    logic [DLY_W:0]   dly_sum_c;
    logic [WID_W:0]   wid_sum_c;
    logic             dly_wrap_c, wid_wrap_c, bus_state_c, abort_now_c, ready_c;

    wb_master_xfer u_xfer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (xfer_req_c),
        .req_pld_i (xfer_pld_c),
        .done_o    (xfer_done),
        .rdat_o    (xfer_rdat),
        .busy_o    (xfer_busy),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .we_o      (we_o),
        .stb_o     (stb_o),
        .cyc_o     (cyc_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            dly_start_q  <= '0;
            dly_stop_q   <= '0;
            dly_step_q   <= '0;
            wid_start_q  <= '0;
            wid_stop_q   <= '0;
            wid_step_q   <= '0;
            cur_dly_q    <= '0;
            cur_wid_q    <= '0;
            attempt_q    <= '0;
            wait_q       <= '0;
            poll_q       <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dly_start_q  <= dly_start_d;
            dly_stop_q   <= dly_stop_d;
            dly_step_q   <= dly_step_d;
            wid_start_q  <= wid_start_d;
            wid_stop_q   <= wid_stop_d;
            wid_step_q   <= wid_step_d;
            cur_dly_q    <= cur_dly_d;
            cur_wid_q    <= cur_wid_d;
            attempt_q    <= attempt_d;
            wait_q       <= wait_d;
            poll_q       <= poll_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            timeout_q    <= timeout_d;
        end
    end

    // Steps are stored already forced to >= 1; the extra sum bit catches wrap past the top.
    assign dly_sum_c   = {1'b0, cur_dly_q} + {1'b0, dly_step_q};
    assign wid_sum_c   = {1'b0, cur_wid_q} + {1'b0, wid_step_q};
    assign dly_wrap_c  = dly_sum_c[DLY_W] || (dly_sum_c[DLY_W-1:0] > dly_stop_q);
    assign wid_wrap_c  = wid_sum_c[WID_W] || (wid_sum_c[WID_W-1:0] > wid_stop_q);
    assign abort_now_c = abort_i || abort_pend_q;
    assign ready_c     = |(xfer_rdat & STATUS_READY);
    assign bus_state_c = (state_q == ST_WR_MODE) || (state_q == ST_WR_WID) ||
                         (state_q == ST_WR_DLY0) || (state_q == ST_WR_DLY1) ||
                         (state_q == ST_FIRE)    || (state_q == ST_POLL);

    // Request payload for the bus state in progress; held off while an abort is pending.
    always_comb begin
        xfer_pld_c = '0;
        xfer_req_c = bus_state_c && !abort_now_c;
        case (state_q)
            ST_WR_MODE: xfer_pld_c = '{we: 1'b1, adr: GLITCH_MODE,    dat: mode_q};
            ST_WR_WID:  xfer_pld_c = '{we: 1'b1, adr: GLITCH_WIDTH,   dat: cur_wid_q};
            ST_WR_DLY0: xfer_pld_c = '{we: 1'b1, adr: GLITCH_DELAY_0, dat: cur_dly_q[7:0]};
            ST_WR_DLY1: xfer_pld_c = '{we: 1'b1, adr: GLITCH_DELAY_1, dat: cur_dly_q[15:8]};
            ST_FIRE:    xfer_pld_c = '{we: 1'b1, adr: GLITCH_STATUS,  dat: STATUS_FIRE};
            ST_POLL:    xfer_pld_c = '{we: 1'b0, adr: GLITCH_STATUS,  dat: '0};
            default:    xfer_pld_c = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dly_start_d  = dly_start_q;
        dly_stop_d   = dly_stop_q;
        dly_step_d   = dly_step_q;
        wid_start_d  = wid_start_q;
        wid_stop_d   = wid_stop_q;
        wid_step_d   = wid_step_q;
        cur_dly_d    = cur_dly_q;
        cur_wid_d    = cur_wid_q;
        attempt_d    = attempt_q;
        wait_d       = wait_q;
        poll_d       = poll_q;
        abort_pend_d = abort_pend_q;
        timeout_d    = timeout_q;
        aborted_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d       = mode_i;
                    dly_start_d  = dly_start_i;
                    dly_stop_d   = dly_stop_i;
                    dly_step_d   = (dly_step_i == '0) ? DLY_W'(1) : dly_step_i;
                    wid_start_d  = wid_start_i;
                    wid_stop_d   = wid_stop_i;
                    wid_step_d   = (wid_step_i == '0) ? WID_W'(1) : wid_step_i;
                    cur_dly_d    = dly_start_i;
                    cur_wid_d    = wid_start_i;
                    attempt_d    = '0;
                    timeout_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if ((dly_start_i > dly_stop_i) || (wid_start_i > wid_stop_i)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WR_MODE;
                    end
                end
            end
            ST_WR_MODE: if (xfer_done) state_d = ST_WR_WID;
            ST_WR_WID:  if (xfer_done) state_d = ST_WR_DLY0;
            ST_WR_DLY0: if (xfer_done) state_d = ST_WR_DLY1;
            ST_WR_DLY1: if (xfer_done) state_d = ST_FIRE;
            ST_FIRE: begin
                if (xfer_done) begin
                    attempt_d = (attempt_q == '1) ? attempt_q : attempt_q + CNT_W'(1);
                    wait_d    = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (32'(wait_q) + 32'd1 >= SETTLE) begin
                    poll_d  = '0;
                    state_d = ST_POLL;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_POLL: begin
                if (xfer_done) begin
                    if (ready_c) begin
                        wait_d  = '0;
                        state_d = ST_HOLDOFF;
                    end else if (32'(poll_q) + 32'd1 >= POLL_TIMEOUT) begin
                        timeout_d = 1'b1;
                        aborted_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        poll_d = poll_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLDOFF: begin
                if (32'(wait_q) + 32'd1 >= HOLDOFF) begin
                    state_d = ST_NEXT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (!dly_wrap_c) begin
                    cur_dly_d = dly_sum_c[DLY_W-1:0];
                    state_d   = ST_WR_WID;
                end else if (!wid_wrap_c) begin
                    cur_dly_d = dly_start_q;
                    cur_wid_d = wid_sum_c[WID_W-1:0];
                    state_d   = ST_WR_WID;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Abort waits for an open bus cycle to ack; otherwise it takes effect at once and
        // overrides whatever the state logic decided this cycle, including a poll timeout.
        if ((state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
            if (xfer_busy) begin
                if (abort_i) abort_pend_d = 1'b1;
            end else if (abort_now_c) begin
                state_d      = ST_IDLE;
                aborted_d    = 1'b1;
                abort_pend_d = 1'b0;
                timeout_d    = timeout_q;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign timeout_o     = timeout_q;
    assign cur_delay_o   = cur_dly_q;
    assign cur_width_o   = cur_wid_q;
    assign attempt_cnt_o = attempt_q;

endmodule
